// File: rtl/data_path_p_if.sv
// data_path_p_if: control strobes, operand inputs and observable outputs of the datapath
interface data_path_p_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int RSW   = $clog2(NREGS)
);
  logic [2:0]       bus1_sel;
  logic [1:0]       bus2_sel;
  logic [WIDTH-1:0] isr1_in;
  logic [WIDTH-1:0] isr2_in;
  logic [WIDTH-1:0] arg_in;
  logic [WIDTH-1:0] data_ram;
  logic             load_pc;
  logic             inc_pc;
  logic             load_ir;
  logic             load_y;
  logic             load_z;
  logic             load_addr;
  logic             gprf_we;
  logic [RSW-1:0]   gprf_wsel;
  logic [RSW-1:0]   gprf_rsel;
  logic             push;
  logic             pop;
  logic [2:0]       alu_select;
  logic [1:0]       fpga_select;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] ir_out;
  logic [WIDTH-1:0] data_to_ram;
  logic [WIDTH-1:0] fpga_out;
  logic [3:0]       alu_flags;
  logic [3:0]       flags_out;
  logic             stk_ovf;
  logic             stk_unf;

  modport master (
    output bus1_sel, bus2_sel, isr1_in, isr2_in, arg_in, data_ram,
           load_pc, inc_pc, load_ir, load_y, load_z, load_addr,
           gprf_we, gprf_wsel, gprf_rsel, push, pop, alu_select, fpga_select,
    input  address, ir_out, data_to_ram, fpga_out, alu_flags, flags_out, stk_ovf, stk_unf
  );

  modport slave (
    input  bus1_sel, bus2_sel, isr1_in, isr2_in, arg_in, data_ram,
           load_pc, inc_pc, load_ir, load_y, load_z, load_addr,
           gprf_we, gprf_wsel, gprf_rsel, push, pop, alu_select, fpga_select,
    output address, ir_out, data_to_ram, fpga_out, alu_flags, flags_out, stk_ovf, stk_unf
  );
endinterface

// File: rtl/data_path_p.sv
// data_path_p: two-bus datapath with ALU, PC/IR/Y/Z/address registers, GPR file and stack pointer
module data_path_p #(
  parameter int WIDTH       = 8,
  parameter int NREGS       = 4,
  parameter int STACK_DEPTH = 16
) (
  input logic         clk,
  input logic         rst,
  data_path_p_if.slave bus
);
  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [WIDTH-1:0] r_pc, r_ir, r_y, r_addr, r_sp;
  logic [3:0]       r_z;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf, r_unf;
  logic [WIDTH-1:0] r_gpr [NREGS];
  logic [WIDTH-1:0] w_bus1, w_bus2, w_alu;
  logic             w_c, w_v;

  // Bus_1 source mux
  always_comb begin
    case (bus.bus1_sel)
      3'd0:    w_bus1 = r_gpr[bus.gprf_rsel];
      3'd1:    w_bus1 = bus.isr1_in;
      3'd2:    w_bus1 = bus.isr2_in;
      3'd3:    w_bus1 = bus.arg_in;
      3'd4:    w_bus1 = r_pc;
      3'd5:    w_bus1 = r_ir;
      3'd6:    w_bus1 = r_sp;
      default: w_bus1 = r_y;
    endcase
  end

  assign w_bus2 = bus.bus2_sel == 2'd0 ? w_alu :
                  bus.bus2_sel == 2'd1 ? w_bus1 :
                  bus.bus2_sel == 2'd2 ? bus.data_ram : '0;

  // ALU with A = Y, B = Bus_1; carry doubles as no-borrow on subtract and shifted-out bit on shifts
  always_comb begin
    w_alu = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.alu_select)
      3'd0: begin
        {w_c, w_alu} = {1'b0, r_y} + {1'b0, w_bus1};
        w_v = (r_y[M] == w_bus1[M]) && (w_alu[M] != r_y[M]);
      end
      3'd1: begin
        w_alu = r_y - w_bus1;
        w_c   = r_y >= w_bus1;
        w_v   = (r_y[M] != w_bus1[M]) && (w_alu[M] != r_y[M]);
      end
      3'd2:    w_alu = r_y & w_bus1;
      3'd3:    w_alu = r_y | w_bus1;
      3'd4:    w_alu = r_y ^ w_bus1;
      3'd5:    w_alu = ~w_bus1;
      3'd6:    {w_c, w_alu} = {r_y, 1'b0};
      default: {w_alu, w_c} = {1'b0, r_y};
    endcase
  end

  assign bus.alu_flags   = {w_v, w_alu[M], w_c, w_alu == '0};
  assign bus.data_to_ram = w_bus1;
  assign bus.address     = r_addr;
  assign bus.ir_out      = r_ir;
  assign bus.flags_out   = r_z;
  assign bus.stk_ovf     = r_ovf;
  assign bus.stk_unf     = r_unf;
  assign bus.fpga_out    = !rst                    ? '0 :
                           bus.fpga_select == 2'd0 ? r_pc :
                           bus.fpga_select == 2'd1 ? w_alu :
                           bus.fpga_select == 2'd2 ? r_gpr[NREGS-1] :
                                                     {{(WIDTH-4){1'b0}}, r_z};

  // Special registers; load_pc wins over inc_pc
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_addr <= '0;
    end else begin
      if (bus.load_pc) r_pc <= w_bus2;
      else if (bus.inc_pc) r_pc <= r_pc + 1'b1;
      if (bus.load_ir) r_ir <= w_bus2;
      if (bus.load_y) r_y <= w_bus2;
      if (bus.load_z) r_z <= bus.alu_flags;
      if (bus.load_addr) r_addr <= w_bus2;
    end
  end

  // General-purpose register file, written from Bus_2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
    end else if (bus.gprf_we) begin
      r_gpr[bus.gprf_wsel] <= w_bus2;
    end
  end

  // Downward-growing stack pointer with occupancy count and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp  <= '1;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (bus.push && !bus.pop) begin
      if (r_cnt == CW'(STACK_DEPTH)) r_ovf <= 1'b1;
      else begin
        r_sp  <= r_sp - 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (bus.pop && !bus.push) begin
      if (r_cnt == '0) r_unf <= 1'b1;
      else begin
        r_sp  <= r_sp + 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_data_path_p.sv
// tb_data_path_p: table-driven vectors plus directed sequences for reset, GPR, stack corners
module tb_data_path_p;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [8:0] LPC = 9'h100, INC = 9'h080, LIR = 9'h040, LY = 9'h020, LZ = 9'h010;
  localparam logic [8:0] LAD = 9'h008, WE = 9'h004, PU = 9'h002, PO = 9'h001, NO = 9'h000;

  typedef struct {
    logic [2:0] b1;
    logic [1:0] b2;
    logic [7:0] arg;
    logic [7:0] ram;
    logic [8:0] ctl;
    logic [1:0] wsel;
    logic [1:0] rsel;
    logic [2:0] alu;
    logic [1:0] fsel;
    logic [7:0] e_fpga;
    logic [3:0] e_flags;
    logic [7:0] e_d2r;
  } vec_t;

  data_path_p_if #(.WIDTH(8), .NREGS(4)) bus ();

  data_path_p #(.WIDTH(8), .NREGS(4), .STACK_DEPTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    bus.bus1_sel    = x.b1;
    bus.bus2_sel    = x.b2;
    bus.arg_in      = x.arg;
    bus.data_ram    = x.ram;
    {bus.load_pc, bus.inc_pc, bus.load_ir, bus.load_y, bus.load_z,
     bus.load_addr, bus.gprf_we, bus.push, bus.pop} = x.ctl;
    bus.gprf_wsel   = x.wsel;
    bus.gprf_rsel   = x.rsel;
    bus.alu_select  = x.alu;
    bus.fpga_select = x.fsel;
  endtask

  task automatic ctl(input logic [8:0] c);
    {bus.load_pc, bus.inc_pc, bus.load_ir, bus.load_y, bus.load_z,
     bus.load_addr, bus.gprf_we, bus.push, bus.pop} = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t v [18];

  initial begin
    v[0]  = '{3'd3, 2'd1, 8'h7F, 8'h00, LY,        2'd0, 2'd0, 3'd0, 2'd0, 8'h00, 4'h0, 8'h7F};
    v[1]  = '{3'd3, 2'd0, 8'h01, 8'h00, LZ,        2'd0, 2'd0, 3'd0, 2'd1, 8'h80, 4'hC, 8'h01};
    v[2]  = '{3'd3, 2'd1, 8'h05, 8'h00, LY,        2'd0, 2'd0, 3'd0, 2'd3, 8'h0C, 4'hC, 8'h05};
    v[3]  = '{3'd3, 2'd0, 8'h05, 8'h00, LZ,        2'd0, 2'd0, 3'd1, 2'd1, 8'h00, 4'h3, 8'h05};
    v[4]  = '{3'd3, 2'd0, 8'h0F, 8'h00, LZ,        2'd0, 2'd0, 3'd2, 2'd1, 8'h05, 4'h0, 8'h0F};
    v[5]  = '{3'd3, 2'd0, 8'h05, 8'h00, LZ,        2'd0, 2'd0, 3'd4, 2'd3, 8'h01, 4'h1, 8'h05};
    v[6]  = '{3'd3, 2'd0, 8'h0F, 8'h00, LZ,        2'd0, 2'd0, 3'd5, 2'd1, 8'hF0, 4'h4, 8'h0F};
    v[7]  = '{3'd3, 2'd1, 8'h81, 8'h00, LY,        2'd0, 2'd0, 3'd0, 2'd0, 8'h00, 4'h4, 8'h81};
    v[8]  = '{3'd3, 2'd0, 8'h00, 8'h00, LZ,        2'd0, 2'd0, 3'd6, 2'd1, 8'h02, 4'h2, 8'h00};
    v[9]  = '{3'd3, 2'd0, 8'h00, 8'h00, LZ,        2'd0, 2'd0, 3'd7, 2'd1, 8'h40, 4'h2, 8'h00};
    v[10] = '{3'd3, 2'd0, 8'h80, 8'h00, LZ,        2'd0, 2'd0, 3'd3, 2'd1, 8'h81, 4'h4, 8'h80};
    v[11] = '{3'd3, 2'd0, 8'h80, 8'h00, LZ,        2'd0, 2'd0, 3'd0, 2'd1, 8'h01, 4'hA, 8'h80};
    v[12] = '{3'd3, 2'd1, 8'h10, 8'h00, LPC | INC, 2'd0, 2'd0, 3'd0, 2'd0, 8'h10, 4'hA, 8'h10};
    v[13] = '{3'd3, 2'd3, 8'h00, 8'h00, INC,       2'd0, 2'd0, 3'd0, 2'd0, 8'h11, 4'hA, 8'h00};
    v[14] = '{3'd3, 2'd1, 8'hFF, 8'h00, LPC,       2'd0, 2'd0, 3'd0, 2'd0, 8'hFF, 4'hA, 8'hFF};
    v[15] = '{3'd3, 2'd3, 8'h00, 8'h00, INC,       2'd0, 2'd0, 3'd0, 2'd0, 8'h00, 4'hA, 8'h00};
    v[16] = '{3'd0, 2'd2, 8'h00, 8'h3C, WE,        2'd1, 2'd1, 3'd0, 2'd0, 8'h00, 4'hA, 8'h3C};
    v[17] = '{3'd6, 2'd3, 8'h00, 8'h00, NO,        2'd0, 2'd0, 3'd0, 2'd0, 8'h00, 4'hA, 8'hFF};

    bus.isr1_in = 8'h00;
    bus.isr2_in = 8'h00;
    apply('{3'd3, 2'd3, 8'h33, 8'h00, NO, 2'd0, 2'd0, 3'd0, 2'd1, 8'h00, 4'h0, 8'h00});
    tick();
    tick();
    chk("reset fpga_out gated", bus.fpga_out, 8'h00);
    chk("reset flags_out", {4'h0, bus.flags_out}, 8'h00);
    bus.bus1_sel = 3'd6;
    #1 chk("reset SP", bus.data_to_ram, 8'hFF);
    bus.bus1_sel = 3'd4;
    #1 chk("reset PC", bus.data_to_ram, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply(v[i]);
      tick();
      chk($sformatf("vec%0d fpga_out", i), bus.fpga_out, v[i].e_fpga);
      chk($sformatf("vec%0d flags_out", i), {4'h0, bus.flags_out}, {4'h0, v[i].e_flags});
      chk($sformatf("vec%0d data_to_ram", i), bus.data_to_ram, v[i].e_d2r);
    end

    apply('{3'd3, 2'd1, 8'h7F, 8'h00, LY, 2'd0, 2'd0, 3'd0, 2'd0, 8'h00, 4'h0, 8'h00});
    tick();
    bus.arg_in = 8'h01;
    ctl(NO);
    #1 chk("live alu_flags add ovf", {4'h0, bus.alu_flags}, 8'h0C);

    apply('{3'd0, 2'd2, 8'h00, 8'hA5, WE, 2'd3, 2'd3, 3'd0, 2'd2, 8'h00, 4'h0, 8'h00});
    #1 chk("gpr3 old via fpga", bus.fpga_out, 8'h00);
    chk("gpr3 old via bus1", bus.data_to_ram, 8'h00);
    tick();
    chk("gpr3 new via fpga", bus.fpga_out, 8'hA5);
    chk("gpr3 new via bus1", bus.data_to_ram, 8'hA5);

    apply('{3'd3, 2'd1, 8'h5A, 8'h00, LIR | LAD, 2'd0, 2'd0, 3'd0, 2'd0, 8'h00, 4'h0, 8'h00});
    #1 chk("ir before edge", bus.ir_out, 8'h00);
    tick();
    chk("ir loaded", bus.ir_out, 8'h5A);
    chk("address loaded", bus.address, 8'h5A);

    apply('{3'd3, 2'd0, 8'h33, 8'h00, PU, 2'd0, 2'd0, 3'd0, 2'd1, 8'h00, 4'h0, 8'h00});
    #2 rst = 1'b0;
    #1 chk("async rst fpga_out", bus.fpga_out, 8'h00);
    chk("async rst flags_out", {4'h0, bus.flags_out}, 8'h00);
    chk("async rst ir", bus.ir_out, 8'h00);
    bus.bus1_sel = 3'd4;
    #1 chk("async rst PC", bus.data_to_ram, 8'h00);
    bus.bus1_sel = 3'd6;
    #1 chk("async rst SP", bus.data_to_ram, 8'hFF);
    bus.bus1_sel = 3'd0;
    bus.gprf_rsel = 2'd3;
    #1 chk("async rst gpr3", bus.data_to_ram, 8'h00);
    ctl(NO);
    @(negedge clk);
    rst = 1'b1;
    bus.bus1_sel = 3'd6;

    ctl(PO);
    tick();
    chk("pop empty SP", bus.data_to_ram, 8'hFF);
    chk("pop empty unf", {7'h0, bus.stk_unf}, 8'h01);
    ctl(PU);
    tick();
    chk("push after unf SP", bus.data_to_ram, 8'hFE);
    chk("unf sticky", {7'h0, bus.stk_unf}, 8'h01);
    ctl(NO);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst clears unf", {7'h0, bus.stk_unf}, 8'h00);
    rst = 1'b1;

    ctl(PU);
    for (int i = 0; i < 16; i++) tick();
    chk("16 pushes SP", bus.data_to_ram, 8'hEF);
    chk("16 pushes ovf", {7'h0, bus.stk_ovf}, 8'h00);
    tick();
    chk("17th push SP", bus.data_to_ram, 8'hEF);
    chk("17th push ovf", {7'h0, bus.stk_ovf}, 8'h01);
    ctl(PU | PO);
    tick();
    chk("push+pop SP", bus.data_to_ram, 8'hEF);
    ctl(PO);
    tick();
    chk("pop after full SP", bus.data_to_ram, 8'hF0);
    chk("ovf sticky", {7'h0, bus.stk_ovf}, 8'h01);
    chk("no unf when popping", {7'h0, bus.stk_unf}, 8'h00);
    ctl(NO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_path_p.md
DATA_PATH_P -- requirements
Module: data_path_p

Interface
REQ-001 Parameter: WIDTH, 8, datapath word width in bits (>=4).
REQ-002 Parameter: NREGS, 4, number of general-purpose registers (power of 2, >=2); RSW = log2(NREGS).
REQ-003 Parameter: STACK_DEPTH, 16, maximum stack entries (1..2^WIDTH-1).
REQ-004 Port: clk  in  1  single system clock, all state updates on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-low.
REQ-006 Port: bus1_sel  in  3  Bus_1 source: 0 GPR[gprf_rsel], 1 isr1_in, 2 isr2_in, 3 arg_in, 4 PC, 5 IR, 6 SP, 7 Y.
REQ-007 Port: bus2_sel  in  2  Bus_2 source: 0 alu_out, 1 Bus_1, 2 data_ram, 3 zero.
REQ-008 Port: isr1_in, isr2_in, arg_in, data_ram  in  WIDTH each  external operand inputs.
REQ-009 Port: load_pc, inc_pc, load_ir, load_y, load_z, load_addr  in  1 each  register strobes.
REQ-010 Port: gprf_we  in  1; gprf_wsel, gprf_rsel  in  RSW  register-file write enable and write/read selects.
REQ-011 Port: push, pop  in  1 each  stack pointer strobes.
REQ-012 Port: alu_select  in  3  ALU opcode.
REQ-013 Port: fpga_select  in  2  debug view select.
REQ-014 Port: address, ir_out, data_to_ram, fpga_out  out  WIDTH  address register, IR, Bus_1 copy, debug view.
REQ-015 Port: alu_flags, flags_out  out  4  live ALU flags {V,N,C,Z}, registered flags (Z register).
REQ-016 Port: stk_ovf, stk_unf  out  1 each  sticky stack overflow/underflow.

Function
REQ-017 Bus_1, Bus_2, alu_out, alu_flags, data_to_ram SHALL be combinational; data_to_ram = Bus_1.
REQ-018 ALU (A = Y, B = Bus_1): 0 A+B, 1 A-B, 2 A&B, 3 A|B, 4 A^B, 5 ~B, 6 A<<1, 7 A>>1 (logical); result WIDTH bits, wraps.
REQ-019 Flags: Z = result==0; N = result MSB; C = carry-out (ADD), no-borrow A>=B (SUB), shifted-out bit (6,7), 0 otherwise; V = signed overflow for ADD/SUB, 0 otherwise.
REQ-020 PC: load_pc loads Bus_2; else inc_pc adds 1 modulo 2^WIDTH; load_pc has priority.
REQ-021 IR, Y, address register SHALL load Bus_2 on their strobes; Z register loads alu_flags on load_z.
REQ-022 GPR file: write Bus_2 into GPR[gprf_wsel] when gprf_we; read is combinational, same-cycle write not visible until next cycle.
REQ-023 Stack state: SP (WIDTH) and count (0..STACK_DEPTH); push alone with count<STACK_DEPTH: SP-1, count+1.
REQ-024 pop alone with count>0: SP+1, count-1.
REQ-025 push at count==STACK_DEPTH: SP/count unchanged, stk_ovf set; pop at count==0: SP/count unchanged, stk_unf set.
REQ-026 push and pop in same cycle: SP, count, flags unchanged.
REQ-027 stk_ovf/stk_unf SHALL remain set until reset.
REQ-028 fpga_out: 0 PC, 1 alu_out, 2 GPR[NREGS-1], 3 {zero-extended flags_out}; SHALL be 0 while rst low.
REQ-029 All register updates take effect one clock after strobe; no other latency.

Reset
REQ-030 rst low SHALL immediately clear PC, IR, Y, Z, address, all GPRs, count, stk_ovf, stk_unf to 0 and set SP to all-ones, independent of clk.
REQ-031 rst release SHALL be synchronised externally; first update occurs on first rising clk edge with rst high.
REQ-032 Reset mid-push/pop SHALL abandon the operation; state equals REQ-030 values.

Verification
REQ-033 Reset: rst low mid-cycle -> PC=0, SP=0xFF, flags_out=0, fpga_out=0 without clock edge (WIDTH=8).
REQ-034 ALU: Y=0x7F, Bus_1=arg_in=0x01, op ADD, load_z -> alu_out=0x80, flags_out V=1,N=1,C=0,Z=0; op SUB Y=0x05,B=0x05 -> Z=1,C=1.
REQ-035 PC: load_pc and inc_pc together with Bus_2=0x10 -> PC=0x10; inc_pc at PC=0xFF -> 0x00.
REQ-036 Stack: 16 pushes -> SP=0xEF, count=16, stk_ovf=0; 17th push -> SP=0xEF, stk_ovf=1; push+pop same cycle -> no change.
REQ-037 Underflow: pop after reset -> SP=0xFF, stk_unf=1, stays 1 after further legal push.
REQ-038 GPR: write 0xA5 to GPR[3] via bus2_sel=2, fpga_select=2 -> fpga_out=0xA5 next cycle; same-cycle read returns old value 0x00.
